vend_sequencer: RTL and testbench

Transaction controller for the vending machine's purchase path. It sits between the debounced select/keypad events and the coin and item managers. On a purchase request it checks stock and the user balance against the selected item's price, commits the debit and the stock decrement, holds the dispense output, and returns change one coin at a time over a valid/ready handshake. It also sequences a full refund on cancel.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/vend_sequencer_picker.sv | 17 +
 rtl/vend_sequencer.sv | 133 +++++++++++++
 tb/tb_vend_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state, coin and status encodings for the purchase path
package vend_pkg;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_COMMIT   = 3'd2;
  localparam logic [2:0] S_DISPENSE = 3'd3;
  localparam logic [2:0] S_CHANGE   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [1:0] COIN_100 = 2'd0;
  localparam logic [1:0] COIN_25  = 2'd1;
  localparam logic [1:0] COIN_10  = 2'd2;
  localparam logic [1:0] COIN_5   = 2'd3;
  localparam logic [1:0] ST_OK           = 2'd0;
  localparam logic [1:0] ST_INSUFFICIENT = 2'd1;
  localparam logic [1:0] ST_SOLD_OUT     = 2'd2;
  localparam logic [1:0] ST_REFUNDED     = 2'd3;
  localparam int MIN_COIN = 5;
  function automatic logic [6:0] coin_cents(input logic [1:0] t);
    return t == COIN_100 ? 7'd100 : t == COIN_25 ? 7'd25 : t == COIN_10 ? 7'd10 : 7'd5;
  endfunction
endpackage

// File: rtl/vend_sequencer_picker.sv
// change_coin_picker: greedy largest coin not exceeding the remaining change
module change_coin_picker import vend_pkg::*; #(
  parameter int BAL_W = 11
) (
  input  logic [BAL_W-1:0] remaining,
  output logic [1:0]       coin_type,
  output logic [BAL_W-1:0] coin_value,
  output logic             has_coin
);
  always_comb begin
    coin_type  = remaining >= BAL_W'(100) ? COIN_100 :
                 remaining >= BAL_W'(25)  ? COIN_25  :
                 remaining >= BAL_W'(10)  ? COIN_10  : COIN_5;
    coin_value = BAL_W'(coin_cents(coin_type));
    has_coin   = remaining >= BAL_W'(MIN_COIN);
  end
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: purchase/refund transaction controller
// All outputs are registered and set on the edge that enters the state they belong to.
module vend_sequencer import vend_pkg::*; #(
  parameter int DISP_CYCLES = 4,
  parameter int BAL_W       = 11,
  parameter int PRICE_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               purchase_mode,
  input  logic               vend_req,
  input  logic               cancel_req,
  input  logic [1:0]         item_idx,
  input  logic [PRICE_W-1:0] item_price,
  input  logic [PRICE_W-1:0] item_stock,
  input  logic [BAL_W-1:0]   balance,
  output logic               balance_load,
  output logic [BAL_W-1:0]   balance_next,
  output logic               stock_dec,
  output logic [1:0]         stock_idx,
  output logic               dispense,
  output logic               coin_valid,
  output logic [1:0]         coin_type,
  input  logic               coin_ready,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status
);
  localparam int CW = DISP_CYCLES > 1 ? $clog2(DISP_CYCLES) : 1;
  logic [2:0]         state;
  logic [BAL_W-1:0]   remaining, bal_q, price_q;
  logic [PRICE_W-1:0] stock_q;
  logic [CW-1:0]      cnt;
  logic [1:0]         pick_type;
  logic [BAL_W-1:0]   pick_value;
  logic               has_coin;
  change_coin_picker #(.BAL_W(BAL_W)) u_picker (
    .remaining  (remaining),
    .coin_type  (pick_type),
    .coin_value (pick_value),
    .has_coin   (has_coin)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      bal_q        <= '0;
      price_q      <= '0;
      stock_q      <= '0;
      cnt          <= '0;
      balance_load <= 1'b0;
      balance_next <= '0;
      stock_dec    <= 1'b0;
      stock_idx    <= '0;
      dispense     <= 1'b0;
      coin_valid   <= 1'b0;
      coin_type    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= ST_OK;
    end else begin
      balance_load <= 1'b0;
      stock_dec    <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE:
          if (purchase_mode && cancel_req) begin
            remaining <= balance;
            status    <= ST_REFUNDED;
            busy      <= 1'b1;
            state     <= S_CHANGE;
          end else if (purchase_mode && vend_req) begin
            stock_idx <= item_idx;
            price_q   <= BAL_W'(item_price);
            stock_q   <= item_stock;
            bal_q     <= balance;
            status    <= ST_OK;
            busy      <= 1'b1;
            state     <= S_CHECK;
          end
        S_CHECK:
          if (stock_q == '0) begin
            status <= ST_SOLD_OUT;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (bal_q < price_q) begin
            status <= ST_INSUFFICIENT;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            balance_load <= 1'b1;
            balance_next <= bal_q - price_q;
            stock_dec    <= 1'b1;
            remaining    <= bal_q - price_q;
            state        <= S_COMMIT;
          end
        S_COMMIT: begin
          dispense <= 1'b1;
          cnt      <= CW'(DISP_CYCLES - 1);
          state    <= S_DISPENSE;
        end
        // the first coin is preloaded so it appears right after dispense drops
        S_DISPENSE:
          if (cnt == '0) begin
            dispense   <= 1'b0;
            coin_valid <= has_coin;
            coin_type  <= pick_type;
            state      <= S_CHANGE;
          end else cnt <= cnt - CW'(1);
        S_CHANGE:
          if (coin_valid) begin
            if (coin_ready) begin
              coin_valid   <= 1'b0;
              remaining    <= remaining - pick_value;
              balance_load <= 1'b1;
              balance_next <= remaining - pick_value;
            end
          end else if (has_coin) begin
            coin_valid <= 1'b1;
            coin_type  <= pick_type;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: scoreboard bench with a transaction-level reference model
module tb_vend_sequencer;
  localparam int DISP = 4, BW = 11, PW = 10;
  localparam int K_LOAD = 0, K_SDEC = 1, K_DISP = 2, K_COIN = 3, K_DONE = 4;
  logic clk = 0, rst_n = 0, purchase_mode = 0, vend_req = 0, cancel_req = 0, coin_ready = 0;
  logic [1:0] item_idx = 0;
  logic [PW-1:0] item_price = 0, item_stock = 0;
  logic [BW-1:0] balance = 0;
  logic balance_load, stock_dec, dispense, coin_valid, busy, done;
  logic [BW-1:0] balance_next;
  logic [1:0] stock_idx, coin_type, status;
  always #5 clk = ~clk;
  vend_sequencer #(.DISP_CYCLES(DISP), .BAL_W(BW), .PRICE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .purchase_mode(purchase_mode), .vend_req(vend_req),
    .cancel_req(cancel_req), .item_idx(item_idx), .item_price(item_price),
    .item_stock(item_stock), .balance(balance), .balance_load(balance_load),
    .balance_next(balance_next), .stock_dec(stock_dec), .stock_idx(stock_idx),
    .dispense(dispense), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_ready(coin_ready), .busy(busy), .done(done), .status(status)
  );
  typedef struct {int kind; int val;} ev_t;
  ev_t exp_q[$];
  int errors = 0, checks = 0;
  string kname[5] = '{"load", "stock_dec", "dispense_len", "coin", "done_status"};
  int coin_vals[4] = '{100, 25, 10, 5};

  function automatic void expect_ev(int k, int v);
    ev_t e;
    e.kind = k;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  function automatic void check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  function automatic void observe(int k, int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s=%0d expected nothing", kname[k], v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event: got %s=%0d expected %s=%0d", kname[k], v, kname[e.kind], e.val);
      end
    end
  endfunction

  // Expected event stream of one accepted request, from the purchase rules
  function automatic void model(bit c, int bal, int price, int stock, int item);
    int rem, st;
    if (c) begin
      rem = bal;
      st = 3;
    end else if (stock == 0) begin
      expect_ev(K_DONE, 2);
      return;
    end else if (bal < price) begin
      expect_ev(K_DONE, 1);
      return;
    end else begin
      rem = bal - price;
      st = 0;
      expect_ev(K_LOAD, rem);
      expect_ev(K_SDEC, item);
      expect_ev(K_DISP, DISP);
    end
    while (rem >= 5)
      for (int t = 0; t < 4; t++)
        if (coin_vals[t] <= rem) begin
          rem -= coin_vals[t];
          expect_ev(K_COIN, t);
          expect_ev(K_LOAD, rem);
          break;
        end
    expect_ev(K_DONE, st);
  endfunction

  initial begin
    int dcnt = 0;
    bit pv = 0, pr = 0;
    logic [1:0] pt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dcnt = 0;
        pv = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (!coin_valid || coin_type != pt) begin
            errors++;
            $display("FAIL coin_hold: got valid=%0b type=%0d expected valid=1 type=%0d", coin_valid, coin_type, pt);
          end
        end
        if (dispense) dcnt++;
        else if (dcnt > 0) begin
          observe(K_DISP, dcnt);
          dcnt = 0;
        end
        if (balance_load) observe(K_LOAD, int'(balance_next));
        if (stock_dec) observe(K_SDEC, int'(stock_idx));
        if (coin_valid && coin_ready) observe(K_COIN, int'(coin_type));
        if (done) observe(K_DONE, int'(status));
        pv = coin_valid;
        pr = coin_ready;
        pt = coin_type;
      end
    end
  end

  task automatic txn(input bit pm, input bit v, input bit c, input int bal, input int price,
                     input int stock, input int item, input int rmode, input int hold,
                     input bit inject, output int n);
    @(posedge clk); #1;
    purchase_mode = pm;
    vend_req = v;
    cancel_req = c;
    balance = BW'(bal);
    item_price = PW'(price);
    item_stock = PW'(stock);
    item_idx = 2'(item);
    coin_ready = 0;
    if (pm && (v || c)) model(c, bal, price, stock, item);
    @(posedge clk); #1;
    vend_req = 0;
    cancel_req = 0;
    balance = BW'($urandom);
    item_price = PW'($urandom);
    item_stock = PW'($urandom);
    item_idx = 2'($urandom);
    n = 1;
    if (!(pm && (v || c))) begin
      repeat (4) @(posedge clk);
      #1;
      check("mode_off_busy", int'(busy), 0);
      return;
    end
    while (!done && n < 600) begin
      coin_ready = rmode == 0 ? 1'b1 : 1'($urandom % 2);
      if (hold > 0 && coin_valid) begin
        coin_ready = 0;
        hold--;
      end
      if (inject && $urandom % 3 == 0) begin
        vend_req = 1;
        cancel_req = 1'($urandom % 2);
        purchase_mode = 1'($urandom % 2);
      end
      @(posedge clk); #1;
      vend_req = 0;
      cancel_req = 0;
      n++;
    end
    check("done_seen", int'(done), 1);
    coin_ready = 0;
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({balance_load, balance_next, stock_dec, stock_idx, dispense,
          coin_valid, coin_type, busy, done, status}), 0);
    rst_n = 1;
    txn(1, 1, 0, 200, 125, 3, 1, 0, 0, 0, n);
    txn(1, 1, 0, 100, 150, 5, 2, 0, 0, 0, n);
    check("insufficient_latency", n, 2);
    txn(1, 1, 0, 50, 150, 0, 3, 0, 0, 0, n);
    check("soldout_latency", n, 2);
    txn(1, 1, 1, 143, 0, 0, 0, 0, 5, 0, n);
    txn(0, 1, 0, 300, 100, 4, 0, 0, 0, 0, n);
    txn(1, 1, 0, 1000, 15, 2, 2, 1, 0, 1, n);
    @(posedge clk); #1;
    purchase_mode = 1;
    cancel_req = 1;
    balance = 11'd2000;
    coin_ready = 0;
    @(posedge clk); #1;
    cancel_req = 0;
    @(posedge clk); #1;
    check("refund_coin_valid", int'(coin_valid), 1);
    rst_n = 0;
    @(posedge clk); #1;
    check("midreset_outputs", int'({balance_load, balance_next, stock_dec, stock_idx, dispense,
          coin_valid, coin_type, busy, done, status}), 0);
    rst_n = 1;
    txn(1, 1, 0, 500, 200, 1, 0, 1, 0, 0, n);
    repeat (40)
      txn(1, 1, ($urandom % 5 == 0), $urandom_range(0, 2047), $urandom_range(0, 1023),
          ($urandom % 4 == 0) ? 0 : $urandom_range(1, 1023), $urandom % 4, 1, $urandom % 4, 1, n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
